// File: rtl/rsp_s2_dma_ahbic_arb_n_if.sv
// Request/select bundle between the input-stage decode, the output-stage arbiter and the slave-side muxes.
// master drives the request and transfer-control signals; slave is the arbiter's view of the bundle.
interface rsp_s2_dma_ahbic_arb_n_if #(
  parameter int NUM_PORTS = 4,
  parameter int PORT_W    = 2
);
  logic [NUM_PORTS-1:0] req_port;
  logic                 HREADYM;
  logic                 HSELM;
  logic [1:0]           HTRANSM;
  logic [2:0]           HBURSTM;
  logic                 HMASTLOCKM;
  logic [PORT_W-1:0]    addr_in_port;
  logic                 no_port;
  logic                 burst_hold;

  modport master (
    output req_port, HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
    input  addr_in_port, no_port, burst_hold
  );

  modport slave (
    input  req_port, HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
    output addr_in_port, no_port, burst_hold
  );
endinterface

// File: rtl/rsp_s2_dma_ahbic_arb_n.sv
// N-port output-stage arbiter with fixed-length burst protection and lock hold.
// Define RSP_S2_DMA_AHBIC_ARB_RR_EN for round-robin priority; otherwise index 0 has fixed highest priority.
module rsp_s2_dma_ahbic_arb_n #(
  parameter int NUM_PORTS = 4,
  parameter int PORT_W    = 2
) (
  input logic                      HCLK,
  input logic                      HRESETn,
  rsp_s2_dma_ahbic_arb_n_if.slave  bus
);

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_BUSY   = 2'b01;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;

  function automatic logic [4:0] burst_len(input logic [2:0] hburst);
    case (hburst)
      3'b000:         return 5'd1;
      3'b001:         return 5'd0;
      3'b010, 3'b011: return 5'd4;
      3'b100, 3'b101: return 5'd8;
      default:        return 5'd16;
    endcase
  endfunction

  function automatic logic [3:0] sat_dec(input logic [3:0] v);
    return (v == 4'd0) ? 4'd0 : v - 4'd1;
  endfunction

  logic [PORT_W-1:0]    addr_in_port_p0;
  logic                 no_port_p0;
  logic [3:0]           beats_left_p0;
  logic [4:0]           burst_l;
  logic [3:0]           rem_next;
  logic                 active;
  logic [NUM_PORTS-1:0] cand;
  logic [PORT_W-1:0]    winner;
  logic [PORT_W-1:0]    addr_next;
  logic                 no_port_next;

  assign active = bus.HSELM && (bus.HTRANSM != HT_IDLE);

  always_comb begin
    burst_l  = burst_len(bus.HBURSTM);
    rem_next = 4'd0;
    if (bus.HSELM) begin
      case (bus.HTRANSM)
        HT_NONSEQ: rem_next = (burst_l == 5'd0) ? 4'd0 : 4'(burst_l - 5'd1);
        HT_SEQ:    rem_next = sat_dec(beats_left_p0);
        HT_BUSY:   rem_next = beats_left_p0;
        default:   rem_next = 4'd0;
      endcase
    end
  end

  // The current owner stays a candidate while it is still transferring.
  always_comb begin
    cand = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      cand[i] = bus.req_port[i] | (active && (addr_in_port_p0 == PORT_W'(i)));
  end

`ifdef RSP_S2_DMA_AHBIC_ARB_RR_EN
  logic [PORT_W-1:0] rr_last_p0;
  logic              found;
  logic              rearb;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 1; k <= NUM_PORTS; k++)
      for (int i = 0; i < NUM_PORTS; i++)
        if (!found && cand[i] && (((int'(rr_last_p0) + k) % NUM_PORTS) == i)) begin
          winner = PORT_W'(i);
          found  = 1'b1;
        end
  end

  assign rearb = !bus.HMASTLOCKM && !(bus.HSELM && (rem_next != 4'd0)) && (|cand);

  always_ff @(posedge HCLK) begin
    if (!HRESETn)
      rr_last_p0 <= PORT_W'(NUM_PORTS - 1);
    else if (bus.HREADYM && rearb)
      rr_last_p0 <= winner;
  end
`else
  always_comb begin
    winner = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--)
      if (cand[i]) winner = PORT_W'(i);
  end
`endif

  always_comb begin
    addr_next    = addr_in_port_p0;
    no_port_next = 1'b0;
    if (bus.HMASTLOCKM)
      addr_next = addr_in_port_p0;
    else if (bus.HSELM && (rem_next != 4'd0))
      addr_next = addr_in_port_p0;
    else if (|cand)
      addr_next = winner;
    else if (!bus.HSELM)
      no_port_next = 1'b1;
  end

  // Selection register stage: everything advances only on a completed transfer.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      addr_in_port_p0 <= '0;
      no_port_p0      <= 1'b1;
      beats_left_p0   <= 4'd0;
    end else if (bus.HREADYM) begin
      addr_in_port_p0 <= addr_next;
      no_port_p0      <= no_port_next;
      beats_left_p0   <= rem_next;
    end
  end

  assign bus.addr_in_port = addr_in_port_p0;
  assign bus.no_port      = no_port_p0;
  assign bus.burst_hold   = (beats_left_p0 != 4'd0);

endmodule

// File: doc/rsp_s2_dma_ahbic_arb_n.md
# rsp_s2_dma_ahbic_arb_n

Parametrised output-stage arbiter for the rsp_s2_dma AHB interconnect. It selects which of NUM_PORTS input stages drives one shared slave port. It adds three behaviours to the single-port arbiter: N-port arbitration, fixed-length burst protection, and optional round-robin priority. The block sits between the input-stage request decode and the output-stage address/data muxes.

## Interface
- NUM_PORTS, 4, number of input stages; range 1..16.
- PORT_W, 2, width of the port index; must satisfy 2**PORT_W >= NUM_PORTS and PORT_W >= 1.
- HCLK  input  1  AHB clock; the only clock.
- HRESETn  input  1  reset; synchronous, active-low.
- req_port  input  NUM_PORTS  bit i is the request from input stage i.
- HREADYM  input  1  slave-side transfer done; all state advances only when it is 1.
- HSELM  input  1  slave select from the currently muxed stage.
- HTRANSM  input  2  transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
- HBURSTM  input  3  burst type, standard AHB encoding.
- HMASTLOCKM  input  1  locked transfer.
- addr_in_port  output  PORT_W  index of the selected input stage.
- no_port  output  1  high when no stage is selected.
- burst_hold  output  1  high while a fixed-length burst is in progress; arbitration is frozen.

## Operation
- Registered state: addr_in_port, no_port, beats_left[3:0], rr_last[PORT_W-1:0].
- All registers update on a rising HCLK edge when HREADYM=1, except reset.
- Reset when HRESETn=0 at a rising edge, regardless of HREADYM: addr_in_port=0, no_port=1, beats_left=0, rr_last=NUM_PORTS-1, burst_hold=0.
- Burst length L decoded from HBURSTM: 000 SINGLE →1; 001 INCR →0 (undefined length); WRAP4/INCR4 →4; WRAP8/INCR8 →8; WRAP16/INCR16 →16.
- rem_next is the number of beats left after the current address phase:
  - HSELM=0 or HTRANSM=IDLE → 0.
  - NONSEQ → L-1, or 0 if L is 0.
  - SEQ → beats_left-1, saturating at 0.
  - BUSY → beats_left.
- beats_left <= rem_next.
- burst_hold = (beats_left != 0), driven directly from the register.
- Next-selection rules, first match wins:
  1. HMASTLOCKM=1 → hold addr_in_port; no_port_next=0.
  2. HSELM=1 and rem_next != 0 → hold addr_in_port; no_port_next=0.
  3. Otherwise build the candidate vector cand[i] = req_port[i] | (addr_in_port==i & HSELM & HTRANSM!=IDLE). If any cand is set, select the winner by the priority scheme; no_port_next=0.
  4. HSELM=1 → hold addr_in_port; no_port_next=0.
  5. Otherwise → hold addr_in_port; no_port_next=1.
- Fixed priority: the lowest set index of cand wins.
- rr_last <= winner whenever rule 3 applies.
- Indices at or above NUM_PORTS are never produced.
- NUM_PORTS=1 degenerates to the single-port arbiter behaviour, plus burst_hold.

## Timing
- Selection latency is one HCLK with HREADYM=1: a request sampled at edge n appears on addr_in_port after edge n.
- While HREADYM=0, outputs and state are frozen and requests are ignored. A request only needs to be present on the HREADYM=1 edge.
- Re-arbitration happens in the cycle in which the final beat's address phase completes. In that cycle rem_next=0, so a new owner is visible for the next address phase.
- IDLE mid-burst (early termination): beats_left clears and arbitration reopens on the same edge.
- Lock and burst at the same time: lock takes precedence. beats_left still tracks the burst.
- A synchronous reset mid-burst drops the burst immediately: no_port=1.

## Configuration
- Macro: RSP_S2_DMA_AHBIC_ARB_RR_EN.
- Defined: round-robin priority in rule 3. The winner is the first set cand index scanning rr_last+1, rr_last+2, …, wrapping modulo NUM_PORTS. The current owner competes at its own rotated position.
- Undefined: fixed priority, with index 0 highest. rr_last is not instantiated.

## Test plan
- Reset: hold HRESETn=0 for 2 cycles with req_port=4'b1111 → no_port=1, addr_in_port=0, burst_hold=0. One cycle after release with HREADYM=1 → addr_in_port=0, no_port=0.
- Fixed priority, macro off: req_port=4'b1010 → addr_in_port=1. Then req_port=4'b1000 with HTRANSM=IDLE → addr_in_port=3.
- INCR4 burst hold: port 2 issues NONSEQ/INCR4 while port 0 requests every cycle → addr_in_port stays 2 across 3 SEQ beats, including one BUSY beat and one HREADYM=0 stall. It switches to 0 on the edge after the 4th address phase; burst_hold is 1 for exactly those beats.
- Round robin, macro on: req_port=4'b1111 held, each grant a SINGLE NONSEQ → grant sequence 0,1,2,3,0.
- Lock: port 3 asserts HMASTLOCKM=1 while req_port=4'b0001 → addr_in_port stays 3 until HMASTLOCKM=0, then becomes 0 on the next HREADYM edge.
- Idle release: req_port=0, HSELM=0 → no_port=1 with addr_in_port unchanged. Then HSELM=1 with IDLE → no_port=0 and the port is held.
